// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the
// instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bus bundle for mem_arbiter.
// slave is the arbiter view, master the environment view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output i_ready, i_rvalid, i_rdata,
        output d_ready, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  i_ready, i_rvalid, i_rdata,
        input  d_ready, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of consecutive instruction-port denials.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter  int STARVE_MAX = DEF_STARVE_MAX,
    localparam int W          = cnt_w(STARVE_MAX)
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max = (cnt_q == W'(STARVE_MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter with data priority,
// bounded fetch starvation and one-cycle read response routing.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    logic              at_max;
    logic              take_i;
    logic              take_d;
    logic              i_gnt;
    logic              d_gnt;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;
    owner_t            owner_q;
    owner_t            owner_d;

    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.i_req && !i_gnt),
        .clr   (!bus.i_req || i_gnt),
        .at_max(at_max)
    );

    assign take_i = bus.i_req && (!bus.d_req || at_max);
    assign take_d = bus.d_req && !take_i;

    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        owner_d   = OWN_NONE;
        unique case (1'b1)
            (!reset && take_i): begin
                i_gnt    = 1'b1;
                addr_mux = bus.i_addr;
                owner_d  = OWN_I;
            end
            (!reset && take_d): begin
                d_gnt     = 1'b1;
                addr_mux  = bus.d_addr;
                wdata_mux = bus.d_wdata;
                owner_d   = bus.d_we ? OWN_NONE : OWN_D;
            end
            default: ;
        endcase
    end

    assign bus.i_ready   = i_gnt;
    assign bus.d_ready   = d_gnt;
    assign bus.mem_en    = i_gnt || d_gnt;
    assign bus.mem_we    = d_gnt && bus.d_we;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;

    // Gating with reset drops a response whose read was issued just before.
    assign bus.i_rvalid = (owner_q == OWN_I) && !reset;
    assign bus.d_rvalid = (owner_q == OWN_D) && !reset;
    assign bus.i_rdata  = bus.mem_rdata;
    assign bus.d_rdata  = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reference arbitration
// model plus a response scoreboard fed at grant time.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    typedef struct {
        bit          is_i;
        logic [31:0] data;
    } resp_t;

    logic clk = 1'b0;
    logic reset;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_MAX(SM)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {24'h0, a[7:0]};
    endfunction

    bit   [31:0] dev_mem [64];
    bit          dev_wr  [64];
    logic [31:0] rdata_q = '0;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                dev_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
                dev_wr[bus.mem_addr[7:2]]  <= 1'b1;
            end else begin
                rdata_q <= dev_wr[bus.mem_addr[7:2]] ?
                           dev_mem[bus.mem_addr[7:2]] :
                           init_word(bus.mem_addr);
            end
        end
    end

    assign bus.mem_rdata = rdata_q;

    int    n_checks = 0;
    int    n_errors = 0;
    int    mcnt     = 0;
    resp_t exp_q[$];
    bit [31:0] ref_mem [64];
    bit        ref_wr  [64];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[7:2]] ? ref_mem[a[7:2]] : init_word(a);
    endfunction

    task automatic step(input bit rst,
                        input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw,
                        input logic [31:0] da, input logic [31:0] dd);
        bit          ig;
        bit          dg;
        logic [31:0] ea;
        resp_t       e;
        reset       = rst;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dd;
        #3;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("i_rvalid", bus.i_rvalid, e.is_i);
            chk("d_rvalid", bus.d_rvalid, !e.is_i);
            if (e.is_i) chk("i_rdata", bus.i_rdata, e.data);
            else        chk("d_rdata", bus.d_rdata, e.data);
        end else begin
            exp_q.delete();
            chk("i_rvalid_idle", bus.i_rvalid, 0);
            chk("d_rvalid_idle", bus.d_rvalid, 0);
        end
        ig = !rst && ir && (!dr || mcnt == SM);
        dg = !rst && dr && !ig;
        ea = ig ? ia : (dg ? da : 32'h0);
        chk("i_ready", bus.i_ready, ig);
        chk("d_ready", bus.d_ready, dg);
        chk("mem_en", bus.mem_en, ig || dg);
        chk("mem_we", bus.mem_we, dg && dw);
        chk("mem_addr", bus.mem_addr, ea);
        if (dg) chk("mem_wdata", bus.mem_wdata, dd);
        if (ig) begin
            exp_q.push_back('{is_i: 1'b1, data: ref_rd(ia)});
        end else if (dg && !dw) begin
            exp_q.push_back('{is_i: 1'b0, data: ref_rd(da)});
        end else if (dg && dw) begin
            ref_mem[da[7:2]] = dd;
            ref_wr[da[7:2]]  = 1'b1;
        end
        if (rst || !ir || ig) mcnt = 0;
        else if (mcnt < SM)   mcnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset with both requesters active: nothing may be granted
        step(1, 1, 32'h0C, 1, 0, 32'h10, 0);
        step(1, 1, 32'h0C, 1, 1, 32'h10, 32'h55);
        idle(10);

        // single fetch, then write/readback of 0x00
        step(0, 1, 32'h0C, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 32'h00, 32'hFF);
        idle(1);
        step(0, 0, 0, 1, 0, 32'h00, 0);
        step(0, 1, 32'h00, 0, 0, 0, 0);
        idle(1);

        // sustained contention: 4 data grants then one fetch
        for (int k = 0; k < 15; k++)
            step(0, 1, 32'h08, 1, 0, 32'h14, 0);
        idle(1);

        // alternating fetch / data read
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) step(0, 1, 32'h04, 0, 0, 0, 0);
            else            step(0, 0, 0, 1, 0, 32'h10, 0);
        end
        idle(1);

        // build starve count, fetch grant, then reset mid-read
        step(0, 1, 32'h20, 1, 0, 32'h24, 0);
        step(0, 1, 32'h20, 1, 0, 32'h24, 0);
        step(0, 1, 32'h28, 0, 0, 0, 0);
        step(1, 1, 32'h28, 1, 0, 32'h24, 0);
        for (int k = 0; k < 7; k++)
            step(0, 1, 32'h2C, 1, 0, 32'h30, 0);
        idle(1);

        // mixed random traffic
        for (int k = 0; k < 60; k++) begin
            step(0, 1'($urandom_range(0, 1)),
                 {24'h0, 4'($urandom_range(0, 15)), 2'b00},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {24'h0, 4'($urandom_range(0, 15)), 2'b00},
                 $urandom());
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of both requesters and the memory.
REQ-002 Parameter DATA_W, 32, data width.
REQ-003 Parameter STARVE_MAX, 4, consecutive instruction-port denials that force an instruction grant; legal range 1..15.
REQ-004 clk  input  1  single clock, all state on posedge.
REQ-005 reset  input  1  synchronous, active-high; sampled on posedge clk.
REQ-006 i_req  input  1  instruction-fetch read request.
REQ-007 i_addr  input  ADDR_W  fetch address.
REQ-008 i_ready  output  1  fetch request accepted this cycle.
REQ-009 i_rvalid  output  1  fetch read data valid.
REQ-010 i_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  data request (read or write).
REQ-012 d_we  input  1  data request is a write.
REQ-013 d_addr  input  ADDR_W  data address.
REQ-014 d_wdata  input  DATA_W  write data.
REQ-015 d_ready  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  data read data valid (reads only).
REQ-017 d_rdata  output  DATA_W  data read data.
REQ-018 mem_en  output  1  memory access issued this cycle.
REQ-019 mem_we  output  1  issued access is a write.
REQ-020 mem_addr  output  ADDR_W  issued address, passed through unmodified.
REQ-021 mem_wdata  output  DATA_W  issued write data.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read issue.

Function
REQ-023 At most one access issued per cycle; grant decision combinational from current requests and registered state; back-to-back issue every cycle allowed.
REQ-024 Only i_req: grant instruction port (i_ready=1, mem_en=1, mem_we=0, mem_addr=i_addr).
REQ-025 Only d_req: grant data port (d_ready=1, mem_en=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata).
REQ-026 Both requesting: data port wins unless starve count equals STARVE_MAX, then instruction port wins.
REQ-027 Starve count: increments when i_req=1 and i_ready=0; clears when i_ready=1 or i_req=0; saturates at STARVE_MAX.
REQ-028 i_ready and d_ready never both 1; neither asserted without its req.
REQ-029 No request: mem_en=0, mem_we=0; mem_addr/mem_wdata don't-care but held at 0.
REQ-030 Response owner register, states OWN_NONE, OWN_I, OWN_D: next = OWN_I on granted fetch, OWN_D on granted data read, OWN_NONE on data write or idle.
REQ-031 Read latency exactly 1 cycle: i_rvalid=1 iff owner=OWN_I; d_rvalid=1 iff owner=OWN_D.
REQ-032 i_rdata and d_rdata both driven from mem_rdata; meaningful only with matching rvalid.
REQ-033 Writes produce no rvalid; write completes in its issue cycle.
REQ-034 Requester holds req/addr/wdata stable until ready; arbiter does not buffer requests.

Reset
REQ-035 On reset: owner=OWN_NONE, starve count=0; cycle after reset i_rvalid=0, d_rvalid=0.
REQ-036 While reset=1: i_ready=0, d_ready=0, mem_en=0, mem_we=0 regardless of requests.
REQ-037 Reset mid-read drops the in-flight response; no rvalid emitted for it.

Structure
REQ-038 Shared package mem_arb_pkg holds owner_t enum (OWN_NONE, OWN_I, OWN_D) and default parameter constants.
REQ-039 One sub-module arb_starve_cnt: saturating counter with inc/clr inputs and at_max output, width ceil(log2(STARVE_MAX+1)).
REQ-040 Top-level contains grant logic, output muxing and owner register only.

Verification
REQ-041 i_req=1 at i_addr=0x0C, d_req=0 -> i_ready=1 same cycle, next cycle i_rvalid=1, i_rdata=mem[0x0C].
REQ-042 d_req=1, d_we=1, d_addr=0x00, d_wdata=0xFF -> d_ready=1, mem_we=1; no d_rvalid next cycle; later read of 0x00 returns 0xFF.
REQ-043 i_req and d_req (reads) held 1 continuously, STARVE_MAX=4 -> 4 data grants then 1 fetch grant, repeating; no port starved beyond 4 cycles.
REQ-044 Alternate fetch 0x04 / data read 0x10 every cycle -> rvalids alternate, each one cycle after its grant, data routed to correct port.
REQ-045 Fetch granted at cycle N, reset=1 at N+1 -> i_rvalid=0 at N+1 and N+2, starve count 0, no grants during reset.
REQ-046 No requests for 10 cycles -> mem_en=0, all ready/rvalid 0 throughout.
